// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller.
// Select encodings follow the register-pair order of the display mux.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2,
    ST_HOLD   = 2'd3
  } disp_state_e;

  localparam logic [3:0] SL_PH0 = 4'b1000;
  localparam logic [3:0] SL_PH1 = 4'b0100;
  localparam logic [3:0] SL_PH2 = 4'b0010;
  localparam logic [3:0] SL_PH3 = 4'b0001;
  localparam logic [3:0] SL_OFF = 4'b0000;

  function automatic logic [3:0] phase_to_sl(input logic [1:0] ph);
    logic [3:0] sl;
    case (ph)
      2'd0:    sl = SL_PH0;
      2'd1:    sl = SL_PH1;
      2'd2:    sl = SL_PH2;
      default: sl = SL_PH3;
    endcase
    return sl;
  endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Loadable down-counter timing both the active slots and the blanking gaps.
// o_tc marks the last cycle of an interval, o_tc_pre the cycle before it.
module disp_slot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_run,
  output logic         o_tc,
  output logic         o_tc_pre
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc     = (r_cnt == '0);
  assign o_tc_pre = (r_cnt == W'(1));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Sequenced 4-phase scan for the multiplexed register display with dead time.
// Define DISP_SCAN_HOLD_EN to build the HOLD state and hold_req/hold_ack handshake.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 166667,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold_req,
  input  logic [1:0] hold_phase,
  output logic       hold_ack,
  output logic [3:0] sl_out,
  output logic [1:0] phase,
  output logic       blank,
  output logic       frame_tick,
  output logic [1:0] dbg_state
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] ACT_LD = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_LD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit NO_BLANK = (BLANK_CYC == 0);

  disp_state_e r_state;
  logic [1:0]  r_phase;
  logic [3:0]  r_sl;
  logic        r_blank;
  logic        r_hold_ack;
  logic        r_hold_pend;
  logic        r_frame_tick;

  logic          w_tc;
  logic          w_tc_pre;
  logic          w_slot_end;
  logic          w_blank_end;
  logic          w_hold_cap;
  logic          w_hold_exit;
  logic          w_hold_move;
  logic [1:0]    w_next_phase;
  logic          w_load_act;
  logic          w_load_blk;
  logic          w_tmr_load;
  logic [CW-1:0] w_tmr_val;
  logic          w_tmr_run;

  // Hold handshake: the requester raises hold_req with hold_phase and keeps it
  // high; hold_ack rises once the display is frozen on that phase and stays high
  // while frozen. Dropping hold_req releases the freeze and hold_ack falls.
  always_comb begin
    w_slot_end  = (r_state == ST_ACTIVE) && w_tc;
    w_blank_end = (r_state == ST_BLANK) && w_tc;
`ifdef DISP_SCAN_HOLD_EN
    w_hold_cap   = w_slot_end && hold_req;
    w_hold_exit  = (r_state == ST_HOLD) && !hold_req;
    w_hold_move  = (r_state == ST_HOLD) && hold_req && (hold_phase != r_phase);
    w_next_phase = w_hold_cap ? hold_phase : r_phase + 2'd1;
`else
    w_hold_cap   = 1'b0;
    w_hold_exit  = 1'b0;
    w_hold_move  = 1'b0;
    w_next_phase = r_phase + 2'd1;
`endif
    w_load_act = ((r_state == ST_IDLE) && en)
               || (w_blank_end && !r_hold_pend)
               || (NO_BLANK && ((w_slot_end && !w_hold_cap) || w_hold_exit));
    w_load_blk = !NO_BLANK && (w_slot_end || w_hold_exit || w_hold_move);
    w_tmr_load = w_load_act || w_load_blk;
    w_tmr_val  = w_load_act ? ACT_LD : BLK_LD;
    w_tmr_run  = (r_state == ST_ACTIVE) || (r_state == ST_BLANK);
  end

  disp_slot_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (!en),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_run      (w_tmr_run),
    .o_tc       (w_tc),
    .o_tc_pre   (w_tc_pre)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_state      <= ST_IDLE;
      r_phase      <= 2'd0;
      r_sl         <= SL_OFF;
      r_blank      <= 1'b1;
      r_hold_ack   <= 1'b0;
      r_hold_pend  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ACTIVE;
          r_phase <= 2'd0;
          r_sl    <= SL_PH0;
          r_blank <= 1'b0;
        end
        ST_ACTIVE: begin
          // Registered tick lands on the final phase-3 cycle, hence the pre-count.
          if ((r_phase == 2'd3) && w_tc_pre) r_frame_tick <= 1'b1;
          if (w_tc) begin
            r_phase     <= w_next_phase;
            r_hold_pend <= w_hold_cap;
            if (NO_BLANK) begin
              r_state    <= w_hold_cap ? ST_HOLD : ST_ACTIVE;
              r_sl       <= phase_to_sl(w_next_phase);
              r_hold_ack <= w_hold_cap;
            end else begin
              r_state <= ST_BLANK;
              r_sl    <= SL_OFF;
              r_blank <= 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (w_tc) begin
            r_sl    <= phase_to_sl(r_phase);
            r_blank <= 1'b0;
            if (r_hold_pend) begin
              r_state    <= ST_HOLD;
              r_hold_ack <= 1'b1;
            end else begin
              r_state <= ST_ACTIVE;
            end
          end
        end
`ifdef DISP_SCAN_HOLD_EN
        ST_HOLD: begin
          if (!hold_req) begin
            r_hold_ack  <= 1'b0;
            r_hold_pend <= 1'b0;
            r_phase     <= r_phase + 2'd1;
            if (NO_BLANK) begin
              r_state <= ST_ACTIVE;
              r_sl    <= phase_to_sl(r_phase + 2'd1);
            end else begin
              r_state <= ST_BLANK;
              r_sl    <= SL_OFF;
              r_blank <= 1'b1;
            end
          end else if (hold_phase != r_phase) begin
            r_phase <= hold_phase;
            if (NO_BLANK) begin
              r_sl <= phase_to_sl(hold_phase);
            end else begin
              r_state    <= ST_BLANK;
              r_hold_ack <= 1'b0;
              r_sl       <= SL_OFF;
              r_blank    <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_sl    <= SL_OFF;
          r_blank <= 1'b1;
        end
      endcase
    end
  end

  assign sl_out     = r_sl;
  assign phase      = r_phase;
  assign blank      = r_blank;
  assign frame_tick = r_frame_tick;
  assign dbg_state  = r_state;

`ifdef DISP_SCAN_HOLD_EN
  assign hold_ack = r_hold_ack;
`else
  logic w_unused_hold;
  assign w_unused_hold = ^{hold_req, hold_phase, r_hold_ack};
  assign hold_ack = 1'b0;
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: vector table on SCAN_DIV=4/BLANK_CYC=2 plus hand
// sequences for the no-blank build, hold handshake and reset during hold.
module tb_disp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       hold_req;
  logic [1:0] hold_phase;

  logic       hold_ack, blank, frame_tick;
  logic [3:0] sl_out;
  logic [1:0] phase, dbg_state;
  logic       z_ack, z_bl, z_tk;
  logic [3:0] z_sl;
  logic [1:0] z_ph, z_dbg;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold_req(hold_req), .hold_phase(hold_phase),
    .hold_ack(hold_ack), .sl_out(sl_out), .phase(phase), .blank(blank),
    .frame_tick(frame_tick), .dbg_state(dbg_state)
  );

  disp_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .hold_req(hold_req), .hold_phase(hold_phase),
    .hold_ack(z_ack), .sl_out(z_sl), .phase(z_ph), .blank(z_bl),
    .frame_tick(z_tk), .dbg_state(z_dbg)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       hreq;
    logic [1:0] hph;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] exp_q[$];
  logic [3:0] sl_map[4];
  logic [3:0] off;
  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [8:0] pk(input logic [3:0] sl, input logic [1:0] ph,
                                    input logic bl, input logic ack, input logic tk);
    return {sl, ph, bl, ack, tk};
  endfunction

  task automatic add(input logic r, input logic e, input logic hr, input logic [1:0] hp,
                     input logic [8:0] x, input string nm);
    vec_t v;
    v.rst_n = r; v.en = e; v.hreq = hr; v.hph = hp; v.exp = x; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic r, input logic e, input logic hr, input logic [1:0] hp,
                       input logic [8:0] x, input bit use0, input string nm);
    logic [8:0] got, want;
    rst_n = r; en = e; hold_req = hr; hold_phase = hp;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got  = use0 ? {z_sl, z_ph, z_bl, z_ack, z_tk} : {sl_out, phase, blank, hold_ack, frame_tick};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s @%0t: got sl=%b ph=%0d blank=%b ack=%b tick=%b, want sl=%b ph=%0d blank=%b ack=%b tick=%b",
               nm, $time, got[8:5], got[4:3], got[2], got[1], got[0],
               want[8:5], want[4:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic rep(input int n, input logic r, input logic e, input logic hr,
                     input logic [1:0] hp, input logic [8:0] x, input string nm);
    for (int i = 0; i < n; i++) apply(r, e, hr, hp, x, 1'b0, nm);
  endtask

  initial begin
    sl_map[0] = 4'b1000; sl_map[1] = 4'b0100; sl_map[2] = 4'b0010; sl_map[3] = 4'b0001;
    off = 4'b0000;
    rst_n = 1'b0; en = 1'b0; hold_req = 1'b0; hold_phase = 2'd0;

    // Main scan table: reset, full frame with wrap, en drop mid phase 1, restart.
    add(0, 0, 0, 0, pk(off, 0, 1, 0, 0), "reset");
    add(0, 1, 0, 0, pk(off, 0, 1, 0, 0), "reset_over_en");
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 4; k++)
        add(1, 1, 0, 0, pk(sl_map[c % 4], 2'(c % 4), 0, 0, (c == 3) && (k == 3)), "scan_active");
      for (int k = 0; k < 2; k++)
        add(1, 1, 0, 0, pk(off, 2'((c + 1) % 4), 1, 0, 0), "scan_blank");
    end
    add(1, 1, 0, 0, pk(sl_map[1], 1, 0, 0, 0), "scan_active");
    add(1, 1, 0, 0, pk(sl_map[1], 1, 0, 0, 0), "scan_active");
    add(1, 0, 0, 0, pk(off, 0, 1, 0, 0), "en_drop");
    add(1, 0, 0, 0, pk(off, 0, 1, 0, 0), "en_idle");
    for (int k = 0; k < 4; k++) add(1, 1, 0, 0, pk(sl_map[0], 0, 0, 0, 0), "reenable");

    foreach (tbl[i]) apply(tbl[i].rst_n, tbl[i].en, tbl[i].hreq, tbl[i].hph, tbl[i].exp, 1'b0, tbl[i].name);

    // No-blank instance: back-to-back slots, tick on last phase-3 cycle, wrap.
    apply(0, 0, 0, 0, pk(off, 0, 1, 0, 0), 1'b1, "nb_reset");
    for (int c = 0; c < 5; c++)
      for (int k = 0; k < 4; k++)
        apply(1, 1, 0, 0, pk(sl_map[c % 4], 2'(c % 4), 0, 0, (c == 3) && (k == 3)), 1'b1, "nb_scan");

`ifdef DISP_SCAN_HOLD_EN
    rep(1, 0, 0, 0, 0, pk(off, 0, 1, 0, 0), "h_reset");
    rep(1, 1, 1, 0, 0, pk(sl_map[0], 0, 0, 0, 0), "h_start");
    rep(3, 1, 1, 1, 2, pk(sl_map[0], 0, 0, 0, 0), "h_req_mid_slot");
    rep(2, 1, 1, 1, 2, pk(off, 2, 1, 0, 0), "h_entry_blank");
    rep(6, 1, 1, 1, 2, pk(sl_map[2], 2, 0, 1, 0), "h_frozen_ph2");
    rep(2, 1, 1, 1, 1, pk(off, 1, 1, 0, 0), "h_move_blank");
    rep(3, 1, 1, 1, 1, pk(sl_map[1], 1, 0, 1, 0), "h_frozen_ph1");
    rep(2, 1, 1, 0, 1, pk(off, 2, 1, 0, 0), "h_release_blank");
    rep(4, 1, 1, 0, 1, pk(sl_map[2], 2, 0, 0, 0), "h_resume_ph2");
    rep(1, 1, 1, 0, 1, pk(off, 3, 1, 0, 0), "h_resume_blank");
    rep(1, 1, 1, 1, 0, pk(off, 3, 1, 0, 0), "h_req_in_blank");
    rep(3, 1, 1, 1, 0, pk(sl_map[3], 3, 0, 0, 0), "h_req_early");
    rep(1, 1, 1, 1, 0, pk(sl_map[3], 3, 0, 0, 1), "h_tick_at_capture");
    rep(2, 1, 1, 1, 0, pk(off, 0, 1, 0, 0), "h_entry_blank2");
    rep(2, 1, 1, 1, 0, pk(sl_map[0], 0, 0, 1, 0), "h_frozen_ph0");
    rep(1, 0, 1, 1, 0, pk(off, 0, 1, 0, 0), "h_reset_in_hold");
    rep(1, 1, 1, 0, 0, pk(sl_map[0], 0, 0, 0, 0), "h_after_reset");
`else
    rep(1, 0, 0, 0, 0, pk(off, 0, 1, 0, 0), "nh_reset");
    rep(4, 1, 1, 1, 2, pk(sl_map[0], 0, 0, 0, 0), "nh_ignore_active0");
    rep(2, 1, 1, 1, 2, pk(off, 1, 1, 0, 0), "nh_ignore_blank");
    rep(4, 1, 1, 1, 2, pk(sl_map[1], 1, 0, 0, 0), "nh_ignore_active1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
